// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared constants, state encoding and helpers for freq_meter
package freq_pkg;

  localparam int C_W_DEF         = 4;
  localparam int MATCH_COUNT_DEF = 2;
  localparam int CNT_SAT_DEF     = 1 << C_W_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  // Saturation value of the period counter for a given code width.
  function automatic int cnt_sat(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// rtl/pulse_sync.sv - 2-flop synchronizer for the pulse input, built only with FREQ_METER_SYNC_EN
`ifdef FREQ_METER_SYNC_EN
module pulse_sync (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`endif

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - recovers the divide code from a pulse strobe train and tracks lock
// Optional input synchronizer: define FREQ_METER_SYNC_EN.
module freq_meter
  import freq_pkg::*;
#(
  parameter int C_W         = C_W_DEF,
  parameter int MATCH_COUNT = MATCH_COUNT_DEF
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic           pulse,
  output logic [C_W-1:0] c,
  output logic           locked,
  output logic           changed
);

  localparam int             CNT_W   = C_W + 1;
  localparam logic [C_W:0]   CNT_SAT = CNT_W'(cnt_sat(C_W));
  localparam logic [C_W:0]   CNT_ONE = CNT_W'(1);
  localparam logic [2:0]     MATCH_T = 3'(MATCH_COUNT);

  logic           evt;
  state_e         state_d, state_q;
  logic [C_W:0]   cnt_d, cnt_q;
  logic [C_W-1:0] cand_d, cand_q;
  logic [2:0]     match_d, match_q;
  logic [C_W-1:0] c_d, c_q;
  logic           locked_d, locked_q;
  logic           changed_d, changed_q;
  logic [C_W-1:0] period;

`ifdef FREQ_METER_SYNC_EN
  pulse_sync u_pulse_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (pulse),
    .q    (evt)
  );
`else
  assign evt = pulse;
`endif

  // Only meaningful once the saturated case has been excluded.
  assign period = cnt_q[C_W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    match_d  = match_q;
    c_d      = c_q;
    locked_d = locked_q;

    if (evt) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (evt) begin
      if (state_q == IDLE) begin
        state_d = ARMED;
      end else if (cnt_q == CNT_SAT) begin
        // Out-of-range period: this event becomes the new reference.
        state_d  = ARMED;
        c_d      = '0;
        locked_d = 1'b0;
      end else begin
        case (state_q)
          ARMED: begin
            cand_d  = period;
            match_d = 3'd1;
            if (MATCH_COUNT == 1) begin
              state_d  = LOCKED;
              c_d      = period;
              locked_d = 1'b1;
            end else begin
              state_d = TRACK;
            end
          end
          TRACK: begin
            if (period == cand_q) begin
              match_d = match_q + 3'd1;
              if (match_d >= MATCH_T) begin
                state_d  = LOCKED;
                c_d      = cand_q;
                locked_d = 1'b1;
              end
            end else begin
              cand_d  = period;
              match_d = 3'd1;
            end
          end
          LOCKED: begin
            if (period != c_q) begin
              state_d  = TRACK;
              locked_d = 1'b0;
              cand_d   = period;
              match_d  = 3'd1;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else if (state_q != IDLE && cnt_q == CNT_SAT) begin
      state_d  = IDLE;
      c_d      = '0;
      locked_d = 1'b0;
    end

    changed_d = (c_d != c_q);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= '0;
      match_q   <= '0;
      c_q       <= '0;
      locked_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      c_q       <= c_d;
      locked_q  <= locked_d;
      changed_q <= changed_d;
    end
  end

  assign c       = c_q;
  assign locked  = locked_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;
  import freq_pkg::*;

  localparam int C_W = 4;
`ifdef FREQ_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           nRst;
  logic           pulse;
  logic [C_W-1:0] c;
  logic           locked;
  logic           changed;

  int n_assert = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;

  freq_meter #(.C_W(C_W), .MATCH_COUNT(2)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .pulse   (pulse),
    .c       (c),
    .locked  (locked),
    .changed (changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nRst === 1'b1 && changed === 1'b1) chg_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [C_W-1:0] ec, input logic el);
    chk({tag, ".c"}, 32'(c), 32'(ec));
    chk({tag, ".locked"}, 32'(locked), 32'(el));
  endtask

  task automatic step(input logic p);
    pulse = p;
    @(posedge clk);
    #1;
  endtask

  // One event followed by p-1 quiet cycles: the next event sees period p.
  task automatic evt(input int p);
    step(1'b1);
    repeat (p - 1) step(1'b0);
  endtask

  initial begin
    nRst  = 1'b0;
    pulse = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step(i[0]);
      chk("rst.c", 32'(c), 32'd0);
      chk("rst.locked", 32'(locked), 32'd0);
      chk("rst.changed", 32'(changed), 32'd0);
    end
    step(1'b0);
    nRst = 1'b1;

    // Period 5: lock at the third event
    evt(5);
    evt(5);
    chk_out("p5_pre", 4'd0, 1'b0);
    step(1'b1);
    repeat (LAT) step(1'b0);
    chk_out("p5_lock", 4'd5, 1'b1);
    chk("p5_changed", 32'(changed), 32'd1);
    repeat (4 - LAT) step(1'b0);
    evt(5);
    evt(5);
    evt(5);
    chk_out("p5_hold", 4'd5, 1'b1);
    chk("p5_strobes", 32'(chg_cnt), 32'd1);

    // Switch 5 -> 9
    evt(9);
    evt(9);
    chk_out("p9_unlock", 4'd5, 1'b0);
    evt(9);
    chk_out("p9_lock", 4'd9, 1'b1);
    chk("p9_strobes", 32'(chg_cnt), 32'd2);

    // Constant high is period 1
    repeat (10) step(1'b1);
    chk_out("dc_lock", 4'd1, 1'b1);
    chk("dc_strobes", 32'(chg_cnt), 32'd3);

    // Lock at 7, then the train stops
    evt(7);
    evt(7);
    evt(7);
    chk_out("p7_lock", 4'd7, 1'b1);
    chk("p7_strobes", 32'(chg_cnt), 32'd4);
    repeat (9 + LAT) step(1'b0);
    chk_out("to_pre", 4'd7, 1'b1);
    step(1'b0);
    chk_out("to_clear", 4'd0, 1'b0);
    chk("to_changed", 32'(changed), 32'd1);
    chk("to_state", 32'(dut.state_q), 32'(IDLE));
    step(1'b0);
    chk("to_changed_end", 32'(changed), 32'd0);
    chk("to_strobes", 32'(chg_cnt), 32'd5);

    // Jitter 6,6,5,6,6
    evt(6);
    evt(6);
    evt(5);
    chk_out("jit_lock", 4'd6, 1'b1);
    evt(6);
    chk_out("jit_unlock", 4'd6, 1'b0);
    evt(6);
    chk_out("jit_track", 4'd6, 1'b0);
    chk("jit_state", 32'(dut.state_q), 32'(TRACK));
    evt(6);
    chk_out("jit_relock", 4'd6, 1'b1);
    chk("jit_strobes", 32'(chg_cnt), 32'd6);

    // Reset asserted mid-TRACK
    evt(8);
    evt(8);
    chk_out("mid_track", 4'd6, 1'b0);
    chk("mid_state", 32'(dut.state_q), 32'(TRACK));
    nRst = 1'b0;
    #1;
    chk_out("mid_rst", 4'd0, 1'b0);
    chk("mid_rst_changed", 32'(changed), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    step(1'b1);
    step(1'b0);
    nRst = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("mid_rst_after", 32'(changed), 32'd0);
    chk("mid_rst_strobes", 32'(chg_cnt), 32'd6);

    // Out-of-range period of exactly 16 re-arms
    evt(5);
    evt(5);
    evt(16);
    chk_out("oor_lock", 4'd5, 1'b1);
    evt(5);
    chk_out("oor_arm", 4'd0, 1'b0);
    chk("oor_state", 32'(dut.state_q), 32'(ARMED));
    evt(5);
    evt(5);
    chk_out("oor_relock", 4'd5, 1'b1);
    chk("oor_strobes", 32'(chg_cnt), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
